mem_access: RTL
===============

Name: mem_access

Overview:
- MEM stage of the five-stage MIPS pipeline. Sits between the EX/MEM register and the MEM/WB register.
- Drives the data-memory bus for loads and stores. Performs byte/half/word alignment, byte-enable generation and load sign/zero extension.
- Holds the pipeline with a stall until the memory acknowledges.
- Passes non-memory instructions straight through to MEM/WB with no added latency.

Parameters:
- TIMEOUT, 16: cycles to wait for dm_ack before aborting with bus_err (range 1..255).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  EX/MEM holds a valid instruction
- in_inst_name  in  8  decoded instruction code
- in_aluResult  in  32  effective address, or ALU result for non-memory ops
- in_storeData  in  32  rt value for stores
- in_writeDataReg  in  5  destination register
- dm_req  out  1  memory request, registered
- dm_we  out  1  1 = store
- dm_addr  out  32  word-aligned address {addr[31:2],2'b00}
- dm_be  out  4  byte enables, bit i = byte lane i (little-endian)
- dm_wdata  out  32  lane-replicated store data
- dm_rdata  in  32  read data, valid when dm_ack=1
- dm_ack  in  1  one-cycle completion pulse
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- memResult  out  32  to MEM/WB
- out_writeDataReg  out  5  to MEM/WB; 0 = no write-back
- out_inst_name  out  8  to MEM/WB
- addr_err  out  1  misaligned-access pulse
- bus_err  out  1  timeout pulse

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, dm_req=0, timeout count=0, captured data=0.
  - addr_err=0, bus_err=0.
  - Combinational outputs follow IDLE rules.
  - A dm_ack arriving after reset with no request outstanding is ignored.
- Memory op:
  - Loads: inst_name ∈ {LB,LH,LW,LBU,LHU}.
  - Stores: inst_name ∈ {SB,SH,SW}.
  - Anything else is a pass-through op.
- Misaligned access:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]≠0.
- IDLE, pass-through op or in_valid=0:
  - stall=0, memResult=in_aluResult.
  - out_writeDataReg=in_writeDataReg if in_valid else 0.
  - out_inst_name=in_inst_name if in_valid else NOP.
- IDLE, valid misaligned memory op:
  - No request is issued. stall=0, out_writeDataReg=0, out_inst_name=NOP.
  - addr_err is registered high for the next cycle only.
- IDLE, valid aligned memory op:
  - stall=1. Bubble to MEM/WB: out_writeDataReg=0, out_inst_name=NOP.
  - Next edge: latch op, addr[1:0] and destination; dm_req←1 with dm_we/dm_addr/dm_be/dm_wdata; count←0; →REQ.
- REQ:
  - dm_req held, bus outputs stable, stall=1, bubble to MEM/WB.
  - On dm_ack: capture the extended load value (stores capture 0), dm_req←0, →RESP.
  - Otherwise count increments. When count==TIMEOUT with no ack: dm_req←0, bus_err←1 for one cycle, →RESP flagged error.
- RESP (exactly one cycle):
  - stall=0, memResult=captured value.
  - out_writeDataReg = latched destination for a load without error; 0 for a store or error.
  - out_inst_name = latched op, or NOP on error.
  - →IDLE. The instruction still on the EX/MEM inputs is the same op and must not re-trigger.
- Latency: an aligned load or store stalls for 1 + N cycles, where N = cycles from dm_req rising to dm_ack (N≥1). An ack in the first dm_req cycle gives N=1.
- Byte enables:
  - SB/LB/LBU: 1<<a.
  - SH/LH/LHU: a[1] ? 4'b1100 : 4'b0011.
  - Word: 4'b1111.
- Store data: SB replicates byte ×4; SH replicates half ×2; SW passes through.
- Load extraction:
  - Byte lane a, half lane a[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- dm_ack in IDLE or RESP is ignored.

Decomposition:
- Shared package mips_pkg, constants for inst_name:
  - NOP=8'h00
  - LB=8'h20, LH=8'h21, LW=8'h23, LBU=8'h24, LHU=8'h25
  - SB=8'h28, SH=8'h29, SW=8'h2B
- mips_pkg also holds the state encoding IDLE/REQ/RESP.
- One sub-module, mem_align (combinational): produces dm_be, dm_wdata and the misaligned flag from (op, addr[1:0], storeData), and extends loads from (op, a, rdata).

Test Plan:
- Pass-through: ADD, aluResult=0x1234, wreg=5 → stall=0, memResult=0x1234, out_writeDataReg=5, dm_req never 1.
- LW, addr=0x100, ack 3 cycles after dm_req rises, rdata=0xDEADBEEF:
  - dm_addr=0x100, dm_be=1111, stall high 4 cycles.
  - RESP memResult=0xDEADBEEF.
- LB, addr=0x103, rdata=0x80FF_FF7F → memResult=0xFFFFFF80. Same stimulus with LBU → 0x00000080.
- SH, addr=0x202, storeData=0x0000ABCD, ack on first cycle:
  - dm_we=1, dm_be=1100, dm_wdata=0xABCDABCD, stall 2 cycles.
  - RESP out_writeDataReg=0.
- LW, addr=0x101 → no dm_req, addr_err one cycle, stall=0, out_writeDataReg=0.
- Timeout and reset:
  - LW with no ack, TIMEOUT=4 → bus_err pulse, dm_req drops, then IDLE.
  - Repeat with rst low mid-REQ → dm_req=0 immediately; a late dm_ack is ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS pipeline MEM stage:
//   - instruction codes carried in inst_name (NOP, loads, stores)
//   - state encoding of the MEM-stage memory FSM
//   - small classification helpers (is_load / is_store / is_mem)
// No ports; imported by mem_align and mem_access.
// ----------------------------------------------------------------------------
package mips_pkg;

   localparam logic [7:0] NOP = 8'h00;
   localparam logic [7:0] LB  = 8'h20;
   localparam logic [7:0] LH  = 8'h21;
   localparam logic [7:0] LW  = 8'h23;
   localparam logic [7:0] LBU = 8'h24;
   localparam logic [7:0] LHU = 8'h25;
   localparam logic [7:0] SB  = 8'h28;
   localparam logic [7:0] SH  = 8'h29;
   localparam logic [7:0] SW  = 8'h2B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } mem_state_t;

   function automatic logic is_load(input logic [7:0] op);
      case (op)
         LB, LH, LW, LBU, LHU: is_load = 1'b1;
         default:              is_load = 1'b0;
      endcase
   endfunction

   function automatic logic is_store(input logic [7:0] op);
      case (op)
         SB, SH, SW: is_store = 1'b1;
         default:    is_store = 1'b0;
      endcase
   endfunction

   function automatic logic is_mem(input logic [7:0] op);
      is_mem = is_load(op) || is_store(op);
   endfunction

endpackage

// File: rtl/mem_align.sv
// ----------------------------------------------------------------------------
// mem_align
// Purely combinational alignment helper for the MEM stage.
//   Store/request side (from the instruction currently in EX/MEM):
//     i_op, i_a, i_store_data -> o_be, o_wdata, o_misaligned
//   Load side (from the latched op and byte offset of the outstanding access):
//     i_ld_op, i_ld_a, i_rdata -> o_ld_data (sign/zero-extended load value)
// Byte lane i of the 32-bit bus is bits [8i+7:8i] (little-endian).
// ----------------------------------------------------------------------------
module mem_align
   import mips_pkg::*;
(
   input  logic [7:0]  i_op,
   input  logic [1:0]  i_a,
   input  logic [31:0] i_store_data,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic        o_misaligned,
   input  logic [7:0]  i_ld_op,
   input  logic [1:0]  i_ld_a,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_ld_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Byte enables, replicated write data and alignment check
   always_comb begin
      o_be         = 4'b0000;
      o_wdata      = i_store_data;
      o_misaligned = 1'b0;
      case (i_op)
         LB, LBU, SB: begin
            o_be    = 4'b0001 << i_a;
            o_wdata = {4{i_store_data[7:0]}};
         end
         LH, LHU, SH: begin
            o_be         = i_a[1] ? 4'b1100 : 4'b0011;
            o_wdata      = {2{i_store_data[15:0]}};
            o_misaligned = i_a[0];
         end
         LW, SW: begin
            o_be         = 4'b1111;
            o_misaligned = |i_a;
         end
         default: ;
      endcase
   end

   // Lane selection for loads: byte lane = a, half lane = a[1]
   always_comb begin
      case (i_ld_a)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      w_half = i_ld_a[1] ? i_rdata[31:16] : i_rdata[15:0];
   end

   always_comb begin
      case (i_ld_op)
         LB:      o_ld_data = {{24{w_byte[7]}}, w_byte};
         LBU:     o_ld_data = {24'h0, w_byte};
         LH:      o_ld_data = {{16{w_half[15]}}, w_half};
         LHU:     o_ld_data = {16'h0, w_half};
         LW:      o_ld_data = i_rdata;
         default: o_ld_data = 32'h0;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// ----------------------------------------------------------------------------
// mem_access
// MEM stage of the five-stage MIPS pipeline (between EX/MEM and MEM/WB).
//   - Issues one data-memory request per aligned load/store, stalling the
//     front of the pipeline until dm_ack (or a timeout) and then presenting
//     the result to MEM/WB for exactly one RESP cycle.
//   - Non-memory ops pass straight through with no added latency.
//   - Misaligned accesses are dropped (bubble) and flagged on addr_err.
// Ports:
//   clk, rst (async, active low)
//   in_*            : EX/MEM register contents
//   dm_*            : data-memory bus (dm_req/we/addr/be/wdata registered)
//   stall           : freeze PC, IF/ID, ID/EX, EX/MEM
//   memResult, out_writeDataReg, out_inst_name : to MEM/WB
//   addr_err, bus_err : one-cycle registered error pulses
//   dbg_state       : current FSM state (mips_pkg::mem_state_t encoding)
// Bus handshake: dm_req rises on the edge leaving IDLE and stays high, with
// all bus fields stable, until the edge on which dm_ack=1 is sampled or the
// timeout expires. dm_ack is only honoured while dm_req is high (REQ state);
// an ack seen in IDLE or RESP is dropped.
// ----------------------------------------------------------------------------
module mem_access
   import mips_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_inst_name,
   input  logic [31:0] in_aluResult,
   input  logic [31:0] in_storeData,
   input  logic [4:0]  in_writeDataReg,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata,
   input  logic        dm_ack,
   output logic        stall,
   output logic [31:0] memResult,
   output logic [4:0]  out_writeDataReg,
   output logic [7:0]  out_inst_name,
   output logic        addr_err,
   output logic        bus_err,
   output logic [1:0]  dbg_state
);

   mem_state_t  r_state;
   mem_state_t  w_next;

   logic [7:0]  r_op;
   logic [1:0]  r_a;
   logic [4:0]  r_dest;
   logic [7:0]  r_count;
   logic [31:0] r_capt;
   logic        r_err;

   logic        w_mem_op;
   logic        w_misaligned;
   logic        w_issue;
   logic        w_reject;
   logic        w_timeout;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_ld_data;

   mem_align u_align (
      .i_op         (in_inst_name),
      .i_a          (in_aluResult[1:0]),
      .i_store_data (in_storeData),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_misaligned (w_misaligned),
      .i_ld_op      (r_op),
      .i_ld_a       (r_a),
      .i_rdata      (dm_rdata),
      .o_ld_data    (w_ld_data)
   );

   assign w_mem_op  = in_valid && is_mem(in_inst_name);
   assign w_issue   = (r_state == IDLE) && w_mem_op && !w_misaligned;
   assign w_reject  = (r_state == IDLE) && w_mem_op && w_misaligned;
   assign w_timeout = (r_count == 8'(TIMEOUT));
   assign dbg_state = r_state;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_issue) w_next = REQ;
         REQ:     if (dm_ack || w_timeout) w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Outputs towards the pipeline
   always_comb begin
      stall            = 1'b0;
      memResult        = in_aluResult;
      out_writeDataReg = in_valid ? in_writeDataReg : 5'd0;
      out_inst_name    = in_valid ? in_inst_name : NOP;
      case (r_state)
         IDLE: begin
            // Any valid memory op is a bubble here; only aligned ones stall
            if (w_mem_op) begin
               stall            = !w_misaligned;
               out_writeDataReg = 5'd0;
               out_inst_name    = NOP;
            end
         end
         REQ: begin
            stall            = 1'b1;
            out_writeDataReg = 5'd0;
            out_inst_name    = NOP;
         end
         RESP: begin
            memResult        = r_capt;
            out_writeDataReg = (is_load(r_op) && !r_err) ? r_dest : 5'd0;
            out_inst_name    = r_err ? NOP : r_op;
         end
         default: ;
      endcase
   end

   // Bus registers, latched access context, timeout counter, error pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dm_req   <= 1'b0;
         dm_we    <= 1'b0;
         dm_addr  <= 32'h0;
         dm_be    <= 4'h0;
         dm_wdata <= 32'h0;
         r_op     <= NOP;
         r_a      <= 2'd0;
         r_dest   <= 5'd0;
         r_count  <= 8'd0;
         r_capt   <= 32'h0;
         r_err    <= 1'b0;
         addr_err <= 1'b0;
         bus_err  <= 1'b0;
      end else begin
         addr_err <= 1'b0;
         bus_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_issue) begin
                  r_op     <= in_inst_name;
                  r_a      <= in_aluResult[1:0];
                  r_dest   <= in_writeDataReg;
                  r_count  <= 8'd0;
                  r_err    <= 1'b0;
                  dm_req   <= 1'b1;
                  dm_we    <= is_store(in_inst_name);
                  dm_addr  <= {in_aluResult[31:2], 2'b00};
                  dm_be    <= w_be;
                  dm_wdata <= w_wdata;
               end else if (w_reject) begin
                  addr_err <= 1'b1;
               end
            end
            REQ: begin
               // An ack on the final counted cycle still wins over the timeout
               if (dm_ack) begin
                  r_capt <= is_load(r_op) ? w_ld_data : 32'h0;
                  dm_req <= 1'b0;
               end else if (w_timeout) begin
                  r_capt  <= 32'h0;
                  r_err   <= 1'b1;
                  dm_req  <= 1'b0;
                  bus_err <= 1'b1;
               end else begin
                  r_count <= r_count + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
